// File: rtl/ram_responder_pkg.sv
// Shared RAM request encodings used by the control unit and the memory-side
// responder, plus a small decode helper.
package ram_responder_pkg;

    localparam logic [1:0] RAM_NONE  = 2'd0;
    localparam logic [1:0] RAM_READ  = 2'd1;
    localparam logic [1:0] RAM_WRITE = 2'd2;

    // True for the two commands that start an access; NONE and the reserved
    // encoding never do.
    function automatic logic is_access(input logic [1:0] op);
        return (op == RAM_READ) || (op == RAM_WRITE);
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port 2^AW x 32 word store with synchronous write. The read port is
// asynchronous; the responder registers the data it returns. Kept on its own
// so it can be replaced by a vendor macro.
module ram_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Store the write data at the clock edge when enabled; no reset so the
    // contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: accepts one READ/WRITE at a time, waits LAT cycles,
// performs the access against ram_array and pulses a one-cycle acknowledge,
// with an error flag for misaligned or out-of-range byte addresses.
// LAT must be in 1..15 so that LAT-1 fits the 4-bit wait counter.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int AW  = 10,
    parameter int LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_ram_do,
    input  logic [31:0] i_ram_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [1:0]    op;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          err;
    logic          accept;
    logic          access;
    logic          addr_bad;
    logic          mem_we;
    logic [AW-1:0] idx;
    logic [31:0]   mem_rdata;

    assign idx      = addr[AW+1:2];
    assign addr_bad = (addr[1:0] != 2'd0) || (addr[31:AW+2] != '0);
    assign mem_we   = access && (op == RAM_WRITE) && !addr_bad;

    ram_array #(
        .AW(AW)
    ) u_array (
        .clk  (i_clk),
        .we   (mem_we),
        .addr (idx),
        .wdata(wdata),
        .rdata(mem_rdata)
    );

    // State register; reset drops any access in flight, including a write
    // that has not reached the array yet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the accept and perform-access strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_access(i_ram_do)) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the command at acceptance, count down the wait, and register
    // the access result; inputs are ignored outside the acceptance edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt   <= 4'd0;
            op    <= RAM_NONE;
            addr  <= 32'd0;
            wdata <= 32'd0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                op    <= i_ram_do;
                addr  <= i_ram_addr;
                wdata <= i_wdata;
                cnt   <= LAT_M1;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err <= addr_bad;
                if (op == RAM_READ) begin
                    rdata <= addr_bad ? 32'd0 : mem_rdata;
                end
            end
        end
    end

    assign o_ack   = (state == ST_RESP);
    assign o_err   = err && (state == ST_RESP);
    assign o_busy  = (state != ST_IDLE);
    assign o_rdata = rdata;

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the core's RAM request interface. It sits opposite the control unit, consuming the `ram_do` command, the byte address and the store data. It services each command from an internal word array after a fixed, parameterised wait. Completion is signalled to the pipeline with a one-cycle acknowledge, plus an error flag for bad addresses.

## Interface
- `AW`, 10: word-address width; array holds 2^AW 32-bit words.
- `LAT`, 2: wait cycles before completion; legal range 1..15.

- `i_clk` in 1: sole clock, rising edge.
- `i_rst` in 1: reset; asynchronous, active-high.
- `i_ram_do` in 2: command, `RAM_NONE`=2'd0, `RAM_READ`=2'd1, `RAM_WRITE`=2'd2; 2'd3 is reserved.
- `i_ram_addr` in 32: byte address; must be word-aligned.
- `i_wdata` in 32: store data, sampled with a `RAM_WRITE`.
- `o_rdata` out 32: read result, valid while `o_ack`=1; holds its value until the next completion.
- `o_ack` out 1: one-cycle completion pulse.
- `o_err` out 1: qualifies `o_ack`; the access was rejected.
- `o_busy` out 1: a command is in flight; new commands are ignored while high.

## Operation
- **States:** IDLE, WAIT, RESP. Encoding is a 2-bit register.
- **IDLE:**
  - A command with `i_ram_do` of READ or WRITE and `o_busy`=0 is accepted at the clock edge.
  - On acceptance, capture the op, address and `i_wdata`, load `cnt`=LAT-1, and go to WAIT.
  - NONE and reserved 2'd3 are never accepted; stay in IDLE.
- **WAIT:**
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access at this edge and go to RESP.
  - **Read:** `o_rdata` ← mem[idx].
  - **Write:** mem[idx] ← captured data; `o_rdata` is unchanged.
- **RESP:** `o_ack`=1 for this cycle only, then go to IDLE unconditionally.
- **Index and error rule** (`idx` = addr[AW+1:2]):
  - A captured address is bad if addr[1:0]≠0 or addr[31:AW+2]≠0.
  - A bad access makes no memory change and sets `o_err`=1 for the RESP cycle.
  - A bad read forces `o_rdata`=0.
- `o_busy`=1 in WAIT and RESP, 0 in IDLE.
- The requester must drop or change its command in the `o_ack` cycle. A command still present once IDLE is re-entered is accepted again as a new access.
- **Ordering:** strictly one access at a time. A read after a write to the same address returns the written value.
- **Reset (any state, including mid-access):**
  - State=IDLE, `cnt`=0.
  - `o_ack`=0, `o_err`=0, `o_busy`=0, `o_rdata`=0.
  - A pending write is discarded.
  - The array is not cleared.

## Timing
- Command sampled at edge E → access performed at edge E+LAT → `o_ack` high for the cycle between edges E+LAT and E+LAT+1.
- IDLE is re-entered at E+LAT+1. The earliest next acceptance is edge E+LAT+2.
- Peak throughput is one access per LAT+2 cycles.
- `o_ack`, `o_err` and `o_busy` are registered state decodes with no combinational path from inputs. `o_rdata` is a register.
- Inputs are sampled only at the acceptance edge. Changes during WAIT/RESP have no effect.
- Asserting `i_rst` asynchronously forces all outputs to reset values immediately. Deassertion takes effect at the next edge.

## Structure
- `RAM_NONE`, `RAM_READ` and `RAM_WRITE` live in the shared defines header already used by the control unit; this block must use them, not redefine them.
- State encodings stay local to the module.
- One sub-module is natural: `ram_array` is a single-port synchronous 2^AW×32 memory with write enable, kept separate so it can be swapped for a vendor macro. FSM, counter and address check stay in `ram_responder`.

## Test plan
- **Reset mid-write:** WRITE addr 0x8 data 0xDEADBEEF, assert `i_rst` in WAIT, then READ 0x8. Mem[2] keeps its prior value, and every output reads 0 during reset.
- **Write then read, LAT=2:** WRITE addr 0x10 data 0xCAFEF00D sampled at edge E gives `o_ack` after E+2 with `o_err`=0. A following READ 0x10 returns `o_rdata`=0xCAFEF00D with `o_ack`.
- **Latency sweep, LAT=1 and LAT=15:** `o_ack` rises exactly LAT edges after acceptance. `o_busy` is high for LAT+1 cycles.
- **Bad addresses:**
  - READ 0x6 (misaligned) gives `o_ack`=`o_err`=1 and `o_rdata`=0.
  - WRITE to 0x1000 with AW=10 (out of range) gives `o_err`=1, and a readback of the aliased word 0x0 is unchanged.
- **Ignored commands:**
  - Change `i_ram_do`/`i_ram_addr` during WAIT: the result reflects the originally captured command only.
  - Hold `i_ram_do`=2'd3 in IDLE for 5 cycles: no `o_busy` and no `o_ack`.
- **Back-to-back traffic:** hold READ 0x4 continuously. Acks repeat every LAT+2 cycles with identical data, and never two in adjacent cycles.
